// File: rtl/data_sram_axi_bridge.sv
// data_sram_axi_bridge
// Turns one SRAM-style load/store request from the memory stage into a single-beat
// AXI4 read or write. While the bus transaction is outstanding, the requester is stalled.
// When the transaction finishes, data_ok pulses for exactly one cycle.
// Optional feature: define DATA_BRIDGE_BUS_ERR_EN to report non-OKAY rresp/bresp on
// bus_error, qualified by data_ok. Without it, bus_error is tied low.
module data_sram_axi_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [2:0]        data_size,
    output logic [31:0]       mem_rdata,
    output logic              data_ok,
    output logic              mem_stall,
    output logic              bus_error,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        size_r;
    logic [3:0]        wen_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;
    logic              aw_done_r;
    logic              w_done_r;
    logic              arvalid_r;
    logic              rready_r;
    logic              awvalid_r;
    logic              wvalid_r;
    logic              bready_r;
    logic              data_ok_r;
`ifdef DATA_BRIDGE_BUS_ERR_EN
    logic              bus_error_r;
`endif

    logic aw_fire_s;
    logic w_fire_s;
    logic aw_done_s;
    logic w_done_s;
    logic unused_s;

    // Handshake detection on the write channels; the done flags include this cycle's fire.
    always_comb begin
        aw_fire_s = awvalid_r & awready;
        w_fire_s  = wvalid_r & wready;
        aw_done_s = aw_done_r | aw_fire_s;
        w_done_s  = w_done_r | w_fire_s;
    end

    // rlast is never needed because the responder guarantees a single beat.
    assign unused_s = ^{rlast, rresp, bresp};

    // Transaction FSM. All bus-facing valids/readies and completion flags are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            addr_r    <= '0;
            size_r    <= 3'd0;
            wen_r     <= 4'd0;
            wdata_r   <= 32'd0;
            rdata_r   <= 32'd0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            data_ok_r <= 1'b0;
`ifdef DATA_BRIDGE_BUS_ERR_EN
            bus_error_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_en) begin
                        addr_r  <= mem_addr;
                        size_r  <= data_size;
                        wen_r   <= mem_wen;
                        wdata_r <= mem_wdata;
                        if (mem_wen == 4'd0) begin
                            arvalid_r <= 1'b1;
                            state_r   <= RD_ADDR;
                        end else begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= WR_REQ;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RD_DATA;
                    end else begin
                        state_r <= RD_ADDR;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready_r  <= 1'b0;
                        rdata_r   <= rdata;
                        data_ok_r <= 1'b1;
`ifdef DATA_BRIDGE_BUS_ERR_EN
                        bus_error_r <= (rresp != 2'b00);
`endif
                        state_r   <= DONE;
                    end else begin
                        state_r <= RD_DATA;
                    end
                end
                WR_REQ: begin
                    // Each channel drops its valid once done; the other may still be waiting.
                    if (aw_fire_s) begin
                        awvalid_r <= 1'b0;
                    end else begin
                        awvalid_r <= awvalid_r;
                    end
                    if (w_fire_s) begin
                        wvalid_r <= 1'b0;
                    end else begin
                        wvalid_r <= wvalid_r;
                    end
                    if (aw_done_s && w_done_s) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        state_r   <= WR_RESP;
                    end else begin
                        aw_done_r <= aw_done_s;
                        w_done_r  <= w_done_s;
                        state_r   <= WR_REQ;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready_r  <= 1'b0;
                        data_ok_r <= 1'b1;
`ifdef DATA_BRIDGE_BUS_ERR_EN
                        bus_error_r <= (bresp != 2'b00);
`endif
                        state_r   <= DONE;
                    end else begin
                        state_r <= WR_RESP;
                    end
                end
                DONE: begin
                    data_ok_r <= 1'b0;
`ifdef DATA_BRIDGE_BUS_ERR_EN
                    bus_error_r <= 1'b0;
`endif
                    state_r   <= IDLE;
                end
                default: begin
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    data_ok_r <= 1'b0;
                    aw_done_r <= 1'b0;
                    w_done_r  <= 1'b0;
`ifdef DATA_BRIDGE_BUS_ERR_EN
                    bus_error_r <= 1'b0;
`endif
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign mem_rdata = rdata_r;
    assign data_ok   = data_ok_r;
    assign mem_stall = mem_en & ~data_ok_r;
`ifdef DATA_BRIDGE_BUS_ERR_EN
    assign bus_error = bus_error_r;
`else
    assign bus_error = 1'b0;
`endif
    assign araddr    = addr_r;
    assign arsize    = size_r;
    assign arvalid   = arvalid_r;
    assign rready    = rready_r;
    assign awaddr    = addr_r;
    assign awsize    = size_r;
    assign awvalid   = awvalid_r;
    assign wdata     = wdata_r;
    assign wstrb     = wen_r;
    assign wlast     = 1'b1;
    assign wvalid    = wvalid_r;
    assign bready    = bready_r;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Testbench for data_sram_axi_bridge: an AXI slave model with programmable wait counts,
// and expected completion cycle / data / error computed from the transaction rules.
module tb_data_sram_axi_bridge;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_en;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        data_size;
    logic [31:0]       mem_rdata;
    logic              data_ok;
    logic              mem_stall;
    logic              bus_error;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awsize;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    int          num_checks = 0;
    int          num_fails  = 0;
    logic [31:0] last_rd    = 32'd0;

    always #5 clk = ~clk;

    data_sram_axi_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .data_size(data_size), .mem_rdata(mem_rdata),
        .data_ok(data_ok), .mem_stall(mem_stall), .bus_error(bus_error),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic [1:0] resp);
`ifdef DATA_BRIDGE_BUS_ERR_EN
        return (resp != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_slave();
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rdata = 32'd0; rresp = 2'b00; bresp = 2'b00;
    endtask

    // One transaction. a_wait: cycles before arready/awready; w_wait: before wready;
    // r_wait: cycles before rvalid/bvalid once rready/bready is seen.
    task automatic run_txn(input logic is_store, input logic [31:0] addr, input logic [2:0] size,
                           input logic [3:0] wen, input logic [31:0] wdat,
                           input int a_wait, input int w_wait, input int r_wait,
                           input logic [31:0] rd_val, input logic [1:0] resp, input logic abort_rd);
        int cyc = 0, exp_cyc;
        int a_seen = 0, w_seen = 0, r_seen = 0;
        int a_hs = 0, w_hs = 0;
        int stall_bad = 0, pay_bad = 0, order_bad = 0;
        logic done = 1'b0;
        if (is_store) exp_cyc = 3 + ((a_wait > w_wait) ? a_wait : w_wait) + r_wait;
        else          exp_cyc = 3 + a_wait + r_wait;
        @(negedge clk);
        mem_en = 1'b1; mem_wen = is_store ? wen : 4'b0000; mem_addr = addr;
        mem_wdata = wdat; data_size = size;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (data_ok) begin
                done = 1'b1;
                check_value("latency", 32'(cyc), 32'(exp_cyc));
                if (!is_store) last_rd = rd_val;
                check_value("mem_rdata", mem_rdata, last_rd);
                check_value("bus_error", {31'd0, bus_error}, {31'd0, exp_err(resp)});
                check_value("stall_in_ok", {31'd0, mem_stall}, 32'd0);
                check_value("addr_hs", 32'(a_hs), 32'd1);
                if (is_store) check_value("w_hs", 32'(w_hs), 32'd1);
                check_value("stall_bad", 32'(stall_bad), 32'd0);
                check_value("payload_bad", 32'(pay_bad), 32'd0);
                check_value("order_bad", 32'(order_bad), 32'd0);
                mem_en = 1'b0;
                clear_slave();
            end else begin
                if (mem_stall !== 1'b1 || bus_error !== 1'b0) stall_bad++;
                if (rready && abort_rd) begin
                    rst = 1'b0;
                    #1;
                    check_value("rst_arvalid", {31'd0, arvalid}, 32'd0);
                    check_value("rst_rready", {31'd0, rready}, 32'd0);
                    check_value("rst_data_ok", {31'd0, data_ok}, 32'd0);
                    check_value("rst_rdata", mem_rdata, 32'd0);
                    last_rd = 32'd0;
                    mem_en = 1'b0;
                    clear_slave();
                    @(negedge clk);
                    rst = 1'b1;
                    return;
                end
                if (arvalid) begin
                    if (araddr !== addr || arsize !== size || is_store) pay_bad++;
                    arready = (a_seen == a_wait);
                    if (arready) a_hs++;
                    a_seen++;
                end else arready = 1'b0;
                if (awvalid) begin
                    if (awaddr !== addr || awsize !== size || !is_store) pay_bad++;
                    awready = (a_seen == a_wait);
                    if (awready) a_hs++;
                    a_seen++;
                end else awready = 1'b0;
                if (wvalid) begin
                    if (wdata !== wdat || wstrb !== wen || wlast !== 1'b1) pay_bad++;
                    wready = (w_seen == w_wait);
                    if (wready) w_hs++;
                    w_seen++;
                end else wready = 1'b0;
                if (rready) begin
                    if (a_hs != 1) order_bad++;
                    rvalid = (r_seen == r_wait);
                    rdata  = rvalid ? rd_val : $urandom;
                    rresp  = resp;
                    r_seen++;
                end else rvalid = 1'b0;
                if (bready) begin
                    if (a_hs != 1 || w_hs != 1) order_bad++;
                    bvalid = (r_seen == r_wait);
                    bresp  = resp;
                    r_seen++;
                end else bvalid = 1'b0;
            end
        end
        if (!done) check_value("timeout", 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; mem_en = 1'b0; mem_wen = 4'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
        data_size = 3'd0; rlast = 1'b1;
        clear_slave();
        repeat (3) @(negedge clk);
        check_value("reset_arvalid", {31'd0, arvalid}, 32'd0);
        check_value("reset_awvalid", {31'd0, awvalid}, 32'd0);
        check_value("reset_wvalid", {31'd0, wvalid}, 32'd0);
        check_value("reset_rready", {31'd0, rready}, 32'd0);
        check_value("reset_bready", {31'd0, bready}, 32'd0);
        check_value("reset_data_ok", {31'd0, data_ok}, 32'd0);
        check_value("reset_bus_error", {31'd0, bus_error}, 32'd0);
        check_value("reset_mem_rdata", mem_rdata, 32'd0);
        rst = 1'b1;

        // Zero-wait load.
        run_txn(1'b0, 32'h1FC0_0010, 3'd2, 4'b0000, 32'd0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0);
        // Byte store, awready two cycles ahead of wready.
        run_txn(1'b1, 32'h0000_0102, 3'd0, 4'b0100, 32'h00AB_0000, 0, 2, 0, 32'd0, 2'b00, 1'b0);
        // Load with arready delayed 3 and rvalid delayed 2: data_ok at cycle 8.
        run_txn(1'b0, 32'h8000_1234, 3'd2, 4'b0000, 32'd0, 3, 0, 2, 32'h1234_5678, 2'b00, 1'b0);
        // Back-to-back loads.
        run_txn(1'b0, 32'h0000_0040, 3'd2, 4'b0000, 32'd0, 0, 0, 0, 32'hCAFE_F00D, 2'b00, 1'b0);
        run_txn(1'b0, 32'h0000_0044, 3'd1, 4'b0000, 32'd0, 0, 0, 0, 32'h0BAD_C0DE, 2'b00, 1'b0);
        // Store with SLVERR response.
        run_txn(1'b1, 32'h0000_0200, 3'd2, 4'b1111, 32'h5555_AAAA, 1, 0, 1, 32'd0, 2'b10, 1'b0);
        // Read with DECERR response still updates mem_rdata.
        run_txn(1'b0, 32'h0000_0300, 3'd2, 4'b0000, 32'd0, 0, 0, 1, 32'h7777_0001, 2'b11, 1'b0);
        // Reset while in RD_DATA, then a fresh load.
        run_txn(1'b0, 32'h0000_0400, 3'd2, 4'b0000, 32'd0, 0, 0, 5, 32'h1111_2222, 2'b00, 1'b1);
        run_txn(1'b0, 32'h0000_0404, 3'd2, 4'b0000, 32'd0, 1, 0, 0, 32'h3333_4444, 2'b00, 1'b0);

        // Randomized mix.
        for (int i = 0; i < 30; i++) begin
            logic        st;
            logic [1:0]  rs;
            st = 1'($urandom_range(1, 0));
            rs = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            run_txn(st, $urandom, 3'($urandom_range(2, 0)), 4'($urandom_range(15, 1)), $urandom,
                    $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                    $urandom, rs, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/data_sram_axi_bridge.md
# data_sram_axi_bridge

Responder for the pipeline's SRAM-style data request interface: it accepts a single load or store described by mem_en/mem_wen/mem_addr/mem_wdata/data_size, performs it as one single-beat AXI4 read or write transaction, and returns read data with a one-cycle completion pulse. It sits between the memory stage and the AXI crossbar, on the uncached data path. It stalls the pipeline while the bus transaction is outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width on both sides.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_en  in  1  request valid; held with all request fields stable until data_ok.
- mem_wen  in  4  byte write strobes; nonzero = store, zero = load.
- mem_addr  in  ADDR_W  byte address, passed to AXI unmodified.
- mem_wdata  in  32  store data, already lane-replicated by requester.
- data_size  in  3  0 byte, 1 half, 2 word; maps directly to AxSIZE.
- mem_rdata  out  32  read data register; valid in data_ok cycle, held afterwards.
- data_ok  out  1  one-cycle completion pulse.
- mem_stall  out  1  = mem_en & ~data_ok (combinational).
- bus_error  out  1  error flag, qualified by data_ok (see Configuration).
- araddr/arsize/arvalid out, arready in; rdata[31:0]/rresp[1:0]/rlast/rvalid in, rready out.
- awaddr/awsize/awvalid out, awready in; wdata[31:0]/wstrb[3:0]/wlast/wvalid out, wready in.
- bresp[1:0]/bvalid in, bready out. ID=0, LEN=0, BURST=INCR, wlast=1 are constants (not ports).

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: if mem_en, latch addr, size, wen, wdata; go RD_ADDR if wen==0 else WR_REQ. No other state samples request inputs.
- RD_ADDR: arvalid=1 with latched addr/size; on arready go RD_DATA.
- RD_DATA: rready=1; on rvalid capture rdata into mem_rdata and rresp; go DONE.
- WR_REQ: awvalid and wvalid raised together; aw_done/w_done flags set on each handshake, valid dropped for that channel once done; when both done (same or different cycles) go WR_RESP, flags cleared.
- WR_RESP: bready=1; on bvalid capture bresp; go DONE.
- DONE: data_ok=1 for exactly one cycle; return IDLE. Next request may be accepted in the following cycle.
- wstrb = latched mem_wen unchanged (partial strobes with size 2 are legal for unaligned stores).
- rlast ignored; responder guarantees single beat.
- Reset: state IDLE; all valid/ready outputs 0, data_ok 0, bus_error 0, mem_rdata 0, latched fields 0. Reset mid-transaction abandons it; requester reissues.
- mem_en deasserted while not in IDLE: undefined by contract; bridge completes the transaction anyway.

## Timing
- Load, arready and rvalid both high at first opportunity: accept cycle 0 (IDLE), arvalid cycle 1, rready/capture cycle 2, data_ok cycle 3. Minimum load latency 3 cycles after accept.
- Store, awready/wready/bvalid immediate: accept 0, AW+W cycle 1, B cycle 2, data_ok cycle 3.
- Each wait cycle on any ready/valid adds exactly one cycle.
- Valids, once raised, stay high with stable payload until handshake.
- Back-to-back: data_ok in cycle N, new accept in N+1.

## Configuration
- DATA_BRIDGE_BUS_ERR_EN defined: bus_error = (captured rresp/bresp != 2'b00) during data_ok, else 0; mem_rdata still updated on erroring read.
- Undefined: bus_error tied 0; resp fields not stored.

## Test plan
- Load 0x1FC0_0010 size 2, slave returns 0xDEADBEEF with zero waits -> arvalid cycle 1, data_ok cycle 3, mem_rdata=0xDEADBEEF, mem_stall high cycles 0-2.
- Store wen=4'b0100 wdata=0x00AB0000 addr 0x0000_0102 size 0; awready 2 cycles before wready -> wstrb=4'b0100, arsize/awsize=0, WR_RESP only after both, single data_ok.
- Read with arready delayed 3 cycles and rvalid delayed 2 -> data_ok at cycle 8; araddr stable throughout.
- Two back-to-back loads -> second arvalid exactly 2 cycles after first data_ok; no duplicate AR.
- With DATA_BRIDGE_BUS_ERR_EN, bresp=2'b10 -> bus_error=1 with data_ok only; without macro bus_error stays 0.
- rst low while in RD_DATA -> arvalid/rready/data_ok 0 immediately (asynchronous), state IDLE; fresh load completes normally.
